// File: rtl/instr_mem_resp.sv
// -----------------------------------------------------------------------------
// instr_mem_resp
//
// Responder end of the instruction-fetch memory interface. A fetch request
// (req_en/req_addr) from the address stage reads the on-chip instruction RAM.
// The word comes back tagged with its address after LATENCY cycles, through a
// pipeline that can be frozen by the consumer (rsp_hold) and emptied on a
// redirect (flush). A host port (ld_*) downloads the program into the RAM.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low (0 = in reset)
//   req_en     in   fetch request strobe
//   req_addr   in   24-bit word address of the fetch
//   req_ready  out  request accepted when req_en & req_ready
//   rsp_hold   in   downstream stall, freezes the response pipeline
//   flush      in   discard all in-flight requests
//   rsp_valid  out  response fields valid
//   rsp_addr   out  address of the returned word
//   rsp_data   out  instruction word (NOP_WORD on a fault)
//   rsp_fault  out  address was outside the RAM
//   ld_we      in   host write strobe
//   ld_addr    in   host write index
//   ld_data    in   host write data
// -----------------------------------------------------------------------------
module instr_mem_resp #(
    parameter int                DATA_W     = 24,
    parameter int                DEPTH_LOG2 = 10,
    parameter int                LATENCY    = 2,
    parameter logic [DATA_W-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_en,
    input  logic [23:0]           req_addr,
    output logic                  req_ready,
    input  logic                  rsp_hold,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic [23:0]           rsp_addr,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_fault,
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data
);

    localparam int ADDR_W = 24;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    // Instruction RAM; never reset, contents survive rst.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Pipeline stages: index 0 holds the registered RAM read, index
    // LATENCY-1 drives the outputs.
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] flt_q, flt_d;
    logic [ADDR_W-1:0]  addr_q [LATENCY];
    logic [ADDR_W-1:0]  addr_d [LATENCY];
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [DATA_W-1:0]  data_d [LATENCY];

    logic                  accept;
    logic                  req_fault;
    logic [DEPTH_LOG2-1:0] req_idx;

    assign req_ready = ~rsp_hold;
    assign accept    = req_en & req_ready;

    // Any set bit above the index range is out of range; the low bits alone
    // would alias onto a valid word, so they are only used when in range.
    assign req_fault = |req_addr[ADDR_W-1:DEPTH_LOG2];
    assign req_idx   = req_addr[DEPTH_LOG2-1:0];

    // -------------------------------------------------------------------------
    // Host load port: writes land at the edge regardless of hold/flush. A
    // fetch sampled at the same edge reads the old word (read-before-write).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // -------------------------------------------------------------------------
    // Stage next-state
    // -------------------------------------------------------------------------
    always_comb begin
        vld_d  = vld_q;
        flt_d  = flt_q;
        addr_d = addr_q;
        data_d = data_q;

        if (!rsp_hold) begin
            // Stage 1: capture the request and the RAM word.
            vld_d[0] = accept;
            if (accept) begin
                addr_d[0] = req_addr;
                flt_d[0]  = req_fault;
                data_d[0] = req_fault ? NOP_WORD : mem_q[req_idx];
            end

            // Later stages: delay registers. Fields move only with a valid
            // entry so that a bubble leaves the previous values in place;
            // entries killed by a flush are not copied either.
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1] && !flush) begin
                    addr_d[i] = addr_q[i-1];
                    flt_d[i]  = flt_q[i-1];
                    data_d[i] = data_q[i-1];
                end
            end
        end

        // Flush beats hold: every older entry dies. A request accepted in the
        // flush cycle is the redirect target and is kept (accept is already 0
        // when hold is also set).
        if (flush) begin
            vld_d    = '0;
            vld_d[0] = accept;
        end
    end

    // -------------------------------------------------------------------------
    // Stage registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            flt_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            flt_q  <= flt_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from the last stage
    // -------------------------------------------------------------------------
    assign rsp_valid = vld_q[LATENCY-1];
    assign rsp_fault = flt_q[LATENCY-1];
    assign rsp_addr  = addr_q[LATENCY-1];
    assign rsp_data  = data_q[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_resp.sv
module tb_instr_mem_resp;

    localparam int          DATA_W     = 24;
    localparam int          DEPTH_LOG2 = 10;
    localparam int          LATENCY    = 2;
    localparam logic [23:0] NOP        = 24'h000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en;
    logic [23:0] req_addr;
    logic        req_ready;
    logic        rsp_hold;
    logic        flush;
    logic        rsp_valid;
    logic [23:0] rsp_addr;
    logic [23:0] rsp_data;
    logic        rsp_fault;
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [23:0] ld_data;

    always #5 clk = ~clk;

    instr_mem_resp #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY   (LATENCY),
        .NOP_WORD  (NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_en   (req_en),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_hold (rsp_hold),
        .flush    (flush),
        .rsp_valid(rsp_valid),
        .rsp_addr (rsp_addr),
        .rsp_data (rsp_data),
        .rsp_fault(rsp_fault),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [23:0] addr;
        logic [23:0] data;
        logic        fault;
        int          stamp;
    } exp_t;

    exp_t        sbq[$];
    logic [23:0] mem_m [1024];
    int          adv     = 0;
    bit          newflag = 1'b0;
    logic [23:0] last_addr  = '0;
    logic [23:0] last_data  = '0;
    logic        last_fault = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted fetch yields one response, in order,
    // carrying the word the RAM held before this edge's host write. A response
    // reaches the outputs after LATENCY non-held edges; flush or reset
    // discards everything still in flight except a request taken with flush.
    always @(posedge clk) begin
        exp_t e;
        newflag = 1'b0;
        if (!rst) begin
            sbq.delete();
        end else begin
            if (flush) sbq.delete();
            if (req_en && !rsp_hold) begin
                e.addr  = req_addr;
                e.fault = (req_addr >= 24'd1024);
                e.data  = e.fault ? NOP : mem_m[req_addr[9:0]];
                e.stamp = adv;
                sbq.push_back(e);
            end
            if (!rsp_hold) begin
                adv++;
                newflag = 1'b1;
            end
        end
        if (ld_we) mem_m[ld_addr] = ld_data;
    end

    // Monitor: a valid output following a non-held edge is a new response.
    // Otherwise the output fields must still show the last response.
    always @(negedge clk) begin
        exp_t e;
        chk("req_ready", {31'd0, req_ready}, {31'd0, ~rsp_hold});
        if (!rst) begin
            chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_addr", {8'd0, rsp_addr}, 32'd0);
            chk("rst_data", {8'd0, rsp_data}, 32'd0);
            chk("rst_fault", {31'd0, rsp_fault}, 32'd0);
            last_addr  = '0;
            last_data  = '0;
            last_fault = 1'b0;
        end else if (newflag && rsp_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got addr %h expected no response (t=%0t)", rsp_addr, $time);
            end else begin
                e = sbq.pop_front();
                chk("rsp_addr", {8'd0, rsp_addr}, {8'd0, e.addr});
                chk("rsp_data", {8'd0, rsp_data}, {8'd0, e.data});
                chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
                chk("latency", adv - e.stamp, LATENCY);
                last_addr  = e.addr;
                last_data  = e.data;
                last_fault = e.fault;
            end
        end else begin
            chk("keep_addr", {8'd0, rsp_addr}, {8'd0, last_addr});
            chk("keep_data", {8'd0, rsp_data}, {8'd0, last_data});
            chk("keep_fault", {31'd0, rsp_fault}, {31'd0, last_fault});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        req_en   = 1'b0;
        req_addr = '0;
        rsp_hold = 1'b0;
        flush    = 1'b0;
        ld_we    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
    endtask

    task automatic req(input logic [23:0] a);
        req_en   = 1'b1;
        req_addr = a;
    endtask

    task automatic ld(input int a, input logic [23:0] d);
        ld_we   = 1'b1;
        ld_addr = a[9:0];
        ld_data = d;
    endtask

    function automatic logic [23:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)      return 24'($urandom_range(0, 15));
        else if (r < 8) return 24'($urandom_range(1008, 1023));
        else            return 24'($urandom_range(1024, 24'hFFFFFF));
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        #1;
        chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);

        // Program download while still in reset; a request now is dropped.
        req(24'd3);
        for (int i = 0; i < 16; i++) begin
            ld(i, (i < 4) ? 24'h100000 + 24'(i) : 24'($urandom));
            tick();
            req_en = 1'b0;
        end
        for (int i = 1008; i < 1024; i++) begin
            ld(i, 24'($urandom));
            tick();
        end
        idle();
        rst = 1'b1;
        tick();

        // Back-to-back stream 0..3.
        for (int i = 0; i < 4; i++) begin
            req(24'(i));
            tick();
        end
        idle();
        repeat (3) tick();

        // Stream with a 3-cycle hold in the middle.
        req(24'd0); tick();
        req(24'd1); tick();
        rsp_hold = 1'b1;
        req(24'd2);
        #1;
        chk("hold_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) tick();
        rsp_hold = 1'b0;
        req(24'd2); tick();
        req(24'd3); tick();
        idle();
        repeat (3) tick();

        // Flush together with the redirect target.
        req(24'd5); tick();
        req(24'd6); tick();
        flush = 1'b1;
        req(24'd10); tick();
        chk("flush_clears", {31'd0, rsp_valid}, 32'd0);
        idle();
        repeat (3) tick();

        // Range boundary.
        req(24'h000400); tick();
        req(24'h0003FF); tick();
        req(24'hFFFFFF); tick();
        idle();
        repeat (3) tick();

        // Read-before-write, then the new word.
        ld(7, 24'hABCDEF);
        req(24'd7); tick();
        ld_we = 1'b0;
        req(24'd7); tick();
        idle();
        repeat (3) tick();

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            req_en   = ($urandom_range(0, 3) != 0);
            req_addr = rand_addr();
            rsp_hold = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            ld_we    = ($urandom_range(0, 4) == 0);
            ld_addr  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15))
                                                    : 10'($urandom_range(1008, 1023));
            ld_data  = 24'($urandom);
            tick();
        end
        idle();
        repeat (4) tick();

        // Asynchronous reset between edges while a response is showing.
        req(24'd1); tick();
        req(24'd2); tick();
        idle();
        chk("pre_reset_valid", {31'd0, rsp_valid}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_rst_addr", {8'd0, rsp_addr}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            req(24'(i));
            tick();
        end
        req(24'h3FF); tick();
        idle();
        repeat (6) tick();

        chk("drain", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
